rc_stream_tx: RTL

- Transmit side of the Toeplitz seed interface. Snapshots a row seed vector (row0, N bits) and a column seed vector (col0, L bits) on a start pulse.
- Streams the snapshot out as BS-bit words over a valid/ready handshake, in the same word order as the c64/r64 hex seed files: all column words first, then all row words.
- Feeds a host/capture link or a seed FIFO so seeds can be exported, checked, or replayed into another extractor instance.

---
 rtl/rc_stream_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rc_stream_tx.sv
// Snapshots a row/column seed pair on start and streams it as BS-bit words.
// First word one cycle after an accepted start; tready low freezes the word in place and start is ignored while a frame is in flight.
module rc_stream_tx #(
   parameter int BS = 64,
   parameter int N  = 256,
   parameter int L  = 128
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [N-1:0]  row0,
   input  logic [L-1:0]  col0,
   output logic [BS-1:0] tdata,
   output logic          tvalid,
   input  logic          tready,
   output logic          tlast,
   output logic          tsel,
   output logic          busy,
   output logic          done
);

   localparam int XSZ  = N / BS;
   localparam int YSZ  = L / BS;
   localparam int MAXW = (XSZ > YSZ) ? XSZ : YSZ;
   localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

   generate
      if ((N % BS) != 0 || (L % BS) != 0 || N < BS || L < BS) begin : g_bad_size
         $error("rc_stream_tx: N and L must be non-zero multiples of BS");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COL  = 2'd1,
      ROW  = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   row_q, row_d;
   logic [L-1:0]   col_q, col_d;
   logic [CW-1:0]  idx_q, idx_d;
   logic           done_q, done_d;
   logic [1:0]     rst_sync_q;
   logic           rst_int_n;
   logic           col_last;
   logic           row_last;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   assign col_last = (idx_q == CW'(YSZ - 1));
   assign row_last = (idx_q == CW'(XSZ - 1));

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   // Shadow vectors shift left on each transfer so the outgoing word is always the top BS bits.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               row_d   = row0;
               col_d   = col0;
               idx_d   = '0;
               state_d = COL;
            end
         end
         COL: begin
            if (tready) begin
               col_d = col_q << BS;
               if (col_last) begin
                  idx_d   = '0;
                  state_d = ROW;
               end else begin
                  idx_d = idx_q + CW'(1);
               end
            end
         end
         ROW: begin
            if (tready) begin
               row_d = row_q << BS;
               if (row_last) begin
                  idx_d   = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      tdata  = '0;
      tvalid = 1'b0;
      tlast  = 1'b0;
      tsel   = 1'b0;
      busy   = 1'b0;
      unique case (state_q)
         COL: begin
            tdata  = col_q[L-1 -: BS];
            tvalid = 1'b1;
            busy   = 1'b1;
         end
         ROW: begin
            tdata  = row_q[N-1 -: BS];
            tvalid = 1'b1;
            tsel   = 1'b1;
            tlast  = row_last;
            busy   = 1'b1;
         end
         default: begin
            tdata  = '0;
         end
      endcase
   end

   assign done = done_q;

endmodule
